alu_4_bit_pipe: RTL and testbench

ALU_4_BIT_PIPE -- requirements
Module: alu_4_bit_pipe

---
 rtl/alu_4_bit_pipe_if.sv | 39 +++
 rtl/alu_4_bit_pipe.sv | 111 +++++++++++
 tb/tb_alu_4_bit_pipe.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_4_bit_pipe_if.sv
// Request/response bundle for alu_4_bit_pipe: operands in, result out, each with valid/ready.
// The zero flag exists only when ALU_FLAGS_EN is defined.
interface alu_4_bit_pipe_if #(
  parameter int DATA_W = 4
);
  logic [1:0]        opcode_bus;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] result;
  logic              carry;
  logic              out_valid;
  logic              out_ready;

`ifdef ALU_FLAGS_EN
  logic              zero;

  modport master (
    output opcode_bus, A, B, in_valid, out_ready,
    input  in_ready, result, carry, out_valid, zero
  );

  modport slave (
    input  opcode_bus, A, B, in_valid, out_ready,
    output in_ready, result, carry, out_valid, zero
  );
`else
  modport master (
    output opcode_bus, A, B, in_valid, out_ready,
    input  in_ready, result, carry, out_valid
  );

  modport slave (
    input  opcode_bus, A, B, in_valid, out_ready,
    output in_ready, result, carry, out_valid
  );
`endif
endinterface

// File: rtl/alu_4_bit_pipe.sv
// Two-stage pipelined 4-bit ALU (add, sub, not A, OR-reduce B) with valid/ready on both sides.
// Optional macro ALU_FLAGS_EN adds a registered zero flag alongside the result.
module alu_4_bit_pipe #(
  parameter int DATA_W = 4
) (
  input logic             clk,
  input logic             reset,
  alu_4_bit_pipe_if.slave bus_io
);

  typedef logic [DATA_W-1:0] alu_input_number_bus_t;

  typedef enum logic [1:0] {
    opcode_add        = 2'd0,
    opcode_sub        = 2'd1,
    opcode_not_a      = 2'd2,
    opcode_reduc_or_b = 2'd3
  } opcode_bus_t;

  logic                  s1_valid_q;
  opcode_bus_t           s1_op_q;
  alu_input_number_bus_t s1_a_q;
  alu_input_number_bus_t s1_b_q;

  logic                  s2_valid_q;
  alu_input_number_bus_t result_q;
  logic                  carry_q;

  alu_input_number_bus_t result_d;
  logic                  carry_d;

  logic                  s2_free;
  logic                  s1_adv;
  logic                  in_ready;
  logic                  in_fire;

  // S1 may advance into an empty S2 or one emptying this cycle; in_ready never looks at in_valid.
  assign s2_free  = !s2_valid_q || bus_io.out_ready;
  assign s1_adv   = s1_valid_q && s2_free;
  assign in_ready = !reset && (!s1_valid_q || s1_adv);
  assign in_fire  = bus_io.in_valid && in_ready;

  always_comb begin
    result_d = '0;
    carry_d  = 1'b0;
    case (s1_op_q)
      opcode_add: {carry_d, result_d} = {1'b0, s1_a_q} + {1'b0, s1_b_q};
      opcode_sub: begin
        result_d = s1_a_q - s1_b_q;
        carry_d  = (s1_a_q < s1_b_q);
      end
      opcode_not_a:      result_d = ~s1_a_q;
      opcode_reduc_or_b: result_d = {{(DATA_W-1){1'b0}}, |s1_b_q};
      default: begin
        result_d = '0;
        carry_d  = 1'b0;
      end
    endcase
  end

`ifdef ALU_FLAGS_EN
  logic zero_q;

  assign bus_io.zero = zero_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= opcode_add;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s2_valid_q <= 1'b0;
      result_q   <= '0;
      carry_q    <= 1'b0;
`ifdef ALU_FLAGS_EN
      zero_q     <= 1'b1;
`endif
    end else begin
      if (in_fire) begin
        s1_op_q <= opcode_bus_t'(bus_io.opcode_bus);
        s1_a_q  <= bus_io.A;
        s1_b_q  <= bus_io.B;
      end

      if (in_fire) begin
        s1_valid_q <= 1'b1;
      end else if (s1_adv) begin
        s1_valid_q <= 1'b0;
      end

      // Result registers only change on a load, so backpressure holds them stable.
      if (s1_adv) begin
        s2_valid_q <= 1'b1;
        result_q   <= result_d;
        carry_q    <= carry_d;
`ifdef ALU_FLAGS_EN
        zero_q     <= (result_d == '0);
`endif
      end else if (bus_io.out_ready) begin
        s2_valid_q <= 1'b0;
      end
    end
  end

  assign bus_io.in_ready  = in_ready;
  assign bus_io.result    = result_q;
  assign bus_io.carry     = carry_q;
  assign bus_io.out_valid = s2_valid_q;

endmodule

// File: tb/tb_alu_4_bit_pipe.sv
// Self-checking bench for alu_4_bit_pipe: directed scenarios plus a scoreboard-checked random stream.
module tb_alu_4_bit_pipe;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_NOT = 2'd2;
  localparam logic [1:0] OP_OR  = 2'd3;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [4:0] expectQ[$];

  alu_4_bit_pipe_if #(.DATA_W(4)) bus ();

  alu_4_bit_pipe #(.DATA_W(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model returns {carry, result}
  function automatic logic [4:0] model(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    int diff;
    case (op)
      OP_ADD: model = 5'(int'(a) + int'(b));
      OP_SUB: begin
        diff  = int'(a) - int'(b);
        model = {(diff < 0), 4'((diff + 16) % 16)};
      end
      OP_NOT:  model = {1'b0, 4'(15 - int'(a))};
      default: model = (b != 4'd0) ? 5'd1 : 5'd0;
    endcase
  endfunction

  // Scoreboard: pops on output transfers, pushes on input transfers, flushes on reset
  always @(negedge clk) begin
    logic [4:0] expv;
    if (reset === 1'b1) begin
      expectQ.delete();
    end else begin
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        checks++;
        if (expectQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL sb_unexpected: got carry=%0d result=%0d, required no output", bus.carry, bus.result);
        end else begin
          expv = expectQ.pop_front();
          if ({bus.carry, bus.result} !== expv) begin
            errors++;
            $display("[TB] FAIL sb_result: got carry=%0d result=%0d, required carry=%0d result=%0d",
                     bus.carry, bus.result, expv[4], expv[3:0]);
          end
`ifdef ALU_FLAGS_EN
          checks++;
          if (bus.zero !== (expv[3:0] == 4'd0)) begin
            errors++;
            $display("[TB] FAIL sb_zero: got %0d, required %0d", bus.zero, (expv[3:0] == 4'd0));
          end
`endif
        end
      end
      if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
        expectQ.push_back(model(bus.opcode_bus, bus.A, bus.B));
      end
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b, input logic valid);
    bus.opcode_bus = op;
    bus.A          = a;
    bus.B          = b;
    bus.in_valid   = valid;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.out_ready = 1'b1;
    drive(OP_ADD, 4'd3, 4'd4, 1'b1);
    repeat (2) nextCycle();
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_in_ready: got %0b, required 0", bus.in_ready);
    end
    checks++;
    if ({bus.out_valid, bus.carry, bus.result} !== 6'b0_0_0000) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got valid=%0b carry=%0b result=%0d, required 0/0/0",
               bus.out_valid, bus.carry, bus.result);
    end
`ifdef ALU_FLAGS_EN
    checks++;
    if (bus.zero !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_zero: got %0b, required 1", bus.zero);
    end
`endif
    reset = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL post_reset_in_ready: got %0b, required 1", bus.in_ready);
    end
    nextCycle();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_discard: got out_valid=%0b, required 0", bus.out_valid);
    end
  endtask

  task automatic test_add();
    bus.out_ready = 1'b1;
    drive(OP_ADD, 4'd15, 4'd1, 1'b1);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL add_in_ready: got %0b, required 1", bus.in_ready);
    end
    nextCycle();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL add_early: got out_valid=%0b, required 0", bus.out_valid);
    end
    nextCycle();
    checks++;
    if ({bus.out_valid, bus.carry, bus.result} !== 6'b1_1_0000) begin
      errors++;
      $display("[TB] FAIL add_15_1: got valid=%0b carry=%0b result=%0d, required 1/1/0",
               bus.out_valid, bus.carry, bus.result);
    end
`ifdef ALU_FLAGS_EN
    checks++;
    if (bus.zero !== 1'b1) begin
      errors++;
      $display("[TB] FAIL add_zero: got %0b, required 1", bus.zero);
    end
`endif
    nextCycle();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL add_drain: got out_valid=%0b, required 0", bus.out_valid);
    end
  endtask

  task automatic test_sub();
    logic [3:0] as[2]   = '{4'd3, 4'd9};
    logic [3:0] bs[2]   = '{4'd5, 4'd4};
    logic [4:0] want[2] = '{5'd30, 5'd5};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i < 2) drive(OP_SUB, as[i], bs[i], 1'b1);
      else bus.in_valid = 1'b0;
      nextCycle();
      if (i >= 1) begin
        checks++;
        if ({bus.out_valid, bus.carry, bus.result} !== {1'b1, want[i-1]}) begin
          errors++;
          $display("[TB] FAIL sub_%0d: got valid=%0b carry=%0b result=%0d, required 1/%0b/%0d",
                   i - 1, bus.out_valid, bus.carry, bus.result, want[i-1][4], want[i-1][3:0]);
        end
      end
    end
    nextCycle();
  endtask

  task automatic test_back_to_back();
    logic [1:0] ops[3]  = '{OP_NOT, OP_OR, OP_OR};
    logic [3:0] as[3]   = '{4'd5, 4'd9, 4'd3};
    logic [3:0] bs[3]   = '{4'd7, 4'd0, 4'd8};
    logic [4:0] want[3] = '{5'd10, 5'd0, 5'd1};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) drive(ops[i], as[i], bs[i], 1'b1);
      else bus.in_valid = 1'b0;
      nextCycle();
      if (i >= 1) begin
        checks++;
        if ({bus.out_valid, bus.carry, bus.result} !== {1'b1, want[i-1]}) begin
          errors++;
          $display("[TB] FAIL b2b_%0d: got valid=%0b carry=%0b result=%0d, required 1/0/%0d",
                   i - 1, bus.out_valid, bus.carry, bus.result, want[i-1][3:0]);
        end
      end
    end
    nextCycle();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_drain: got out_valid=%0b, required 0", bus.out_valid);
    end
  endtask

  task automatic test_backpressure();
    int   k = 1;
    int   accepted = 0;
    logic ready;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(OP_ADD, 4'(k), 4'(k), 1'b1);
      #1;
      ready = bus.in_ready;
      if (i >= 2) begin
        checks++;
        if (ready !== 1'b0) begin
          errors++;
          $display("[TB] FAIL bp_in_ready_%0d: got %0b, required 0", i, ready);
        end
        checks++;
        if ({bus.out_valid, bus.carry, bus.result} !== 6'b1_0_0010) begin
          errors++;
          $display("[TB] FAIL bp_hold_%0d: got valid=%0b carry=%0b result=%0d, required 1/0/2",
                   i, bus.out_valid, bus.carry, bus.result);
        end
      end
      nextCycle();
      if (ready === 1'b1) begin
        accepted++;
        k++;
      end
    end
    checks++;
    if (accepted != 2) begin
      errors++;
      $display("[TB] FAIL bp_accepted: got %0d, required 2", accepted);
    end
    drive(OP_ADD, 4'(k), 4'(k), 1'b1);
    bus.out_ready = 1'b1;
    nextCycle();
    bus.in_valid = 1'b0;
    checks++;
    if ({bus.out_valid, bus.result} !== 5'b1_0100) begin
      errors++;
      $display("[TB] FAIL bp_release_4: got valid=%0b result=%0d, required 1/4", bus.out_valid, bus.result);
    end
    nextCycle();
    checks++;
    if ({bus.out_valid, bus.result} !== 5'b1_0110) begin
      errors++;
      $display("[TB] FAIL bp_release_6: got valid=%0b result=%0d, required 1/6", bus.out_valid, bus.result);
    end
    nextCycle();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_drain: got out_valid=%0b, required 0", bus.out_valid);
    end
  endtask

  task automatic test_reset_flush();
    bus.out_ready = 1'b1;
    drive(OP_ADD, 4'd7, 4'd7, 1'b1);
    nextCycle();
    bus.in_valid = 1'b0;
    reset = 1'b1;
    nextCycle();
    checks++;
    if ({bus.out_valid, bus.carry, bus.result, bus.in_ready} !== 7'b0) begin
      errors++;
      $display("[TB] FAIL flush_reset: got valid=%0b carry=%0b result=%0d in_ready=%0b, required all 0",
               bus.out_valid, bus.carry, bus.result, bus.in_ready);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL flush_in_ready: got %0b, required 1", bus.in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL flush_reappear_%0d: got out_valid=%0b, required 0", i, bus.out_valid);
      end
    end
  endtask

  task automatic test_random_stream();
    for (int i = 0; i < 300; i++) begin
      drive(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 3) != 0));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      nextCycle();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10 && expectQ.size() != 0; i++) nextCycle();
    checks++;
    if (expectQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL random_drain: got %0d pending, required 0", expectQ.size());
    end
  endtask

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.opcode_bus = OP_ADD;
    bus.A         = 4'd0;
    bus.B         = 4'd0;
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_backpressure();
    test_reset_flush();
    test_random_stream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
